if_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the ID decode block.
- Holds the PC and drives a synchronous-read instruction memory (1-cycle read latency).
- Presents a registered Instruction/PC pair with a valid bit to ID.
- Honours the load-use stall from hazard detection and the branch/jump redirect from EX.

---
 rtl/if_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage: instruction fetch stage and the IF/ID pipeline register.
//
// Holds the PC and drives a synchronous-read instruction memory, which returns
// data one enabled edge after the address is presented. The IF/ID register
// gives Decode a registered instruction, its PC and a valid bit.
//
// Ports
//   clk                in   rising-edge clock
//   reset              in   synchronous, active-high; overrides everything
//   stall              in   load-use stall; freezes fetch and IF/ID
//   flush              in   taken redirect from EX; overrides stall
//   redirect_pc        in   redirect target, used while flush=1
//   imem_addr          out  instruction memory address (the PC register)
//   imem_en            out  memory read enable; memory output holds when low
//   imem_rdata         in   word for the address latched on the last enabled edge
//   IF_ID_PC           out  PC of the instruction held in IF/ID
//   IF_ID_PCplus4      out  IF_ID_PC + 4, modulo 2^32
//   IF_ID_Instruction  out  instruction handed to Decode
//   IF_ID_valid        out  IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PCplus4,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  // Memory must also read on a flush edge, even under stall, so the redirect
  // is not held up; the word it returns is discarded via fetch_valid.
  assign imem_en   = ~reset & (flush | ~stall);
  assign imem_addr = pc_q;

  always_comb begin
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (flush) begin
      pc_d          = {redirect_pc[31:2], 2'b00};
      fetch_valid_d = 1'b0;
      if_id_pc_d    = 32'h0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d          = pc_q + 32'd4;
      fetch_pc_d    = pc_q;
      fetch_valid_d = 1'b1;
      if_id_pc_d    = fetch_pc_q;
      if_id_instr_d = imem_rdata;
      if_id_valid_d = fetch_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      fetch_pc_q    <= 32'h0;
      fetch_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign IF_ID_PC          = if_id_pc_q;
  assign IF_ID_PCplus4     = if_id_pc_q + 32'd4;
  assign IF_ID_Instruction = if_id_instr_q;
  assign IF_ID_valid       = if_id_valid_q;

endmodule
